// File: rtl/gray_decoder_stream.sv
// Streaming Gray-to-binary decoder with a one-beat registered output stage,
// a single-bit-step checker against the previously accepted code and a saturating error counter.
module gray_decoder_stream #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_gray,
    input  logic                 clear_err,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     out_bin,
    output logic                 out_err,
    output logic [ERR_CNT_W-1:0] err_count
);

    typedef enum logic {
        NO_PREV   = 1'b0,
        HAVE_PREV = 1'b1
    } hist_t;

    hist_t            state, state_nxt;
    logic [WIDTH-1:0] prev_gray, prev_gray_nxt;
    logic [WIDTH-1:0] dec_bin;
    logic             accept;
    logic             step_err;
    logic             err_nxt;
    logic             cnt_sat;

    // The output register frees up in the same cycle the sink takes its beat.
    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;
    assign cnt_sat  = &err_count;
    assign step_err = ($countones(in_gray ^ prev_gray) != 1);

    // Binary bit i is the XOR of all Gray bits at positions i and above.
    always_comb begin
        dec_bin = '0;
        for (int i = 0; i < WIDTH; i++) begin
            dec_bin[i] = ^(in_gray >> i);
        end
    end

    // NOTE: every output of this block gets a default first, so no path leaves a value
    // unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        prev_gray_nxt = prev_gray;
        err_nxt       = 1'b0;
        if (accept) begin
            prev_gray_nxt = in_gray;
            state_nxt     = HAVE_PREV;
            // A simultaneous clear makes this beat the first of a new history.
            err_nxt       = (state == HAVE_PREV) && !clear_err && step_err;
        end else if (clear_err) begin
            state_nxt = NO_PREV;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= NO_PREV;
            prev_gray <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_err   <= 1'b0;
            err_count <= '0;
        end else begin
            state     <= state_nxt;
            prev_gray <= prev_gray_nxt;

            if (accept) begin
                out_valid <= 1'b1;
                out_bin   <= dec_bin;
                out_err   <= err_nxt;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end

            if (clear_err) begin
                err_count <= '0;
            end else if (err_nxt && !cnt_sat) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_gray_decoder_stream.sv
// Bench for gray_decoder_stream: directed scenarios with literal expectations plus randomized
// traffic checked every cycle against a table-driven behavioural model.
module tb_gray_decoder_stream;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         clear_err = 1'b0;
    logic         out_ready = 1'b0;
    logic [W-1:0] in_gray = '0;

    logic         in_ready, out_valid, out_err;
    logic [W-1:0] out_bin;
    logic [7:0]   err_count;

    logic         s_in_ready, s_out_valid, s_out_err;
    logic [W-1:0] s_out_bin;
    logic [1:0]   s_err_count;

    gray_decoder_stream #(.WIDTH(W), .ERR_CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_gray(in_gray),
        .clear_err(clear_err), .out_valid(out_valid), .out_ready(out_ready), .out_bin(out_bin),
        .out_err(out_err), .err_count(err_count)
    );

    gray_decoder_stream #(.WIDTH(W), .ERR_CNT_W(2)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(s_in_ready), .in_gray(in_gray),
        .clear_err(clear_err), .out_valid(s_out_valid), .out_ready(out_ready), .out_bin(s_out_bin),
        .out_err(s_out_err), .err_count(s_err_count)
    );

    always #5 clk = ~clk;

    int n_cmp  = 0;
    int n_fail = 0;

    // Behavioural model state.
    bit           m_valid;
    logic [W-1:0] m_bin;
    bit           m_err;
    bit           m_have;
    logic [W-1:0] m_prev;
    int           m_cnt;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Inverse Gray by table search: the n whose Gray code n^(n>>1) equals g.
    function automatic logic [W-1:0] gray_to_bin(input logic [W-1:0] g);
        logic [W-1:0] n;
        gray_to_bin = '0;
        for (int k = 0; k < (1 << W); k++) begin
            n = k[W-1:0];
            if ((n ^ (n >> 1)) == g) gray_to_bin = n;
        end
    endfunction

    task automatic model_reset();
        m_valid = 0; m_bin = '0; m_err = 0; m_have = 0; m_prev = '0; m_cnt = 0;
    endtask

    task automatic model_step();
        bit acc;
        acc = in_valid && (!m_valid || out_ready);
        if (acc) begin
            m_bin = gray_to_bin(in_gray);
            if (clear_err || !m_have) m_err = 0;
            else m_err = ($countones(in_gray ^ m_prev) != 1);
            m_prev  = in_gray;
            m_have  = 1;
            m_valid = 1;
            if (clear_err) m_cnt = 0;
            else if (m_err) m_cnt++;
        end else begin
            if (m_valid && out_ready) m_valid = 0;
            if (clear_err) begin
                m_cnt  = 0;
                m_have = 0;
            end
        end
    endtask

    task automatic compare_all();
        check("in_ready", {31'd0, in_ready}, {31'd0, (!m_valid || out_ready)});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_valid});
        check("err_count", {24'd0, err_count}, (m_cnt > 255) ? 32'd255 : m_cnt);
        check("sat_out_valid", {31'd0, s_out_valid}, {31'd0, m_valid});
        check("sat_err_count", {30'd0, s_err_count}, (m_cnt > 3) ? 32'd3 : m_cnt);
        if (m_valid) begin
            check("out_bin", {28'd0, out_bin}, {28'd0, m_bin});
            check("out_err", {31'd0, out_err}, {31'd0, m_err});
            check("sat_out_bin", {28'd0, s_out_bin}, {28'd0, m_bin});
            check("sat_out_err", {31'd0, s_out_err}, {31'd0, m_err});
        end
    endtask

    // One clock: drive at the falling edge, step the model at the rising edge, compare at the next falling edge.
    task automatic cycle(input bit v, input logic [W-1:0] g, input bit ordy, input bit clr);
        in_valid = v; in_gray = g; out_ready = ordy; clear_err = clr;
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        logic [W-1:0] g;
        logic [W-1:0] last_g;
        int sat_exp [5] = '{1, 2, 3, 3, 3};

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_bin", {28'd0, out_bin}, 32'd0);
        check("rst_out_err", {31'd0, out_err}, 32'd0);
        check("rst_err_count", {24'd0, err_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // T1 sweep
        for (int i = 0; i < 16; i++) begin
            g = i[W-1:0] ^ (i[W-1:0] >> 1);
            cycle(1, g, 1, 0);
            check("t1_bin", {28'd0, out_bin}, i);
            check("t1_err", {31'd0, out_err}, 32'd0);
        end
        check("t1_cnt", {24'd0, err_count}, 32'd0);

        // T2 backpressure
        cycle(1, 4'b0000, 1, 0);
        cycle(1, 4'b0001, 1, 0);
        cycle(1, 4'b0011, 1, 0);
        check("t2_bin_0011", {28'd0, out_bin}, 32'd2);
        for (int k = 0; k < 3; k++) begin
            cycle(1, 4'b0010, 0, 0);
            check("t2_in_ready_low", {31'd0, in_ready}, 32'd0);
            check("t2_bin_held", {28'd0, out_bin}, 32'd2);
            check("t2_valid_held", {31'd0, out_valid}, 32'd1);
        end
        cycle(1, 4'b0010, 1, 0);
        check("t2_bin_0010", {28'd0, out_bin}, 32'd3);
        check("t2_err_0010", {31'd0, out_err}, 32'd0);
        cycle(0, 4'b0000, 1, 0);
        check("t2_drained", {31'd0, out_valid}, 32'd0);

        // T3 step error
        cycle(0, 4'b0000, 1, 1);
        check("t3_clr_cnt", {24'd0, err_count}, 32'd0);
        cycle(1, 4'b0000, 1, 0);
        check("t3_first_err", {31'd0, out_err}, 32'd0);
        cycle(1, 4'b0011, 1, 0);
        check("t3_bin", {28'd0, out_bin}, 32'd2);
        check("t3_err", {31'd0, out_err}, 32'd1);
        check("t3_cnt1", {24'd0, err_count}, 32'd1);
        cycle(1, 4'b0011, 1, 0);
        check("t3_repeat_err", {31'd0, out_err}, 32'd1);
        check("t3_cnt2", {24'd0, err_count}, 32'd2);

        // T4 wrap and clear-with-accept
        cycle(1, 4'b1000, 1, 0);
        cycle(1, 4'b0000, 1, 0);
        check("t4_wrap_err", {31'd0, out_err}, 32'd0);
        cycle(1, 4'b0110, 1, 1);
        check("t4_clr_cnt", {24'd0, err_count}, 32'd0);
        check("t4_clr_err", {31'd0, out_err}, 32'd0);
        check("t4_clr_bin", {28'd0, out_bin}, 32'd4);

        // T5 saturation on the 2-bit counter instance
        cycle(1, 4'b0000, 1, 1);
        for (int k = 0; k < 5; k++) begin
            cycle(1, 4'b0000, 1, 0);
            check("t5_sat_cnt", {30'd0, s_err_count}, sat_exp[k]);
            check("t5_main_cnt", {24'd0, err_count}, k + 1);
        end

        // Randomized traffic, mostly legal single-bit steps
        last_g = 4'b0000;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(3) != 0) g = last_g ^ (4'b0001 << $urandom_range(W - 1));
            else g = W'($urandom);
            last_g = g;
            cycle(($urandom_range(3) != 0), g, ($urandom_range(3) != 0), ($urandom_range(31) == 0));
        end

        // T6 asynchronous reset mid-stream
        cycle(1, 4'b0011, 0, 0);
        check("t6_pre_valid", {31'd0, out_valid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("t6_rst_valid", {31'd0, out_valid}, 32'd0);
        check("t6_rst_bin", {28'd0, out_bin}, 32'd0);
        check("t6_rst_err", {31'd0, out_err}, 32'd0);
        check("t6_rst_cnt", {24'd0, err_count}, 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cycle(1, 4'b0101, 1, 0);
        check("t6_first_bin", {28'd0, out_bin}, 32'd6);
        check("t6_first_err", {31'd0, out_err}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
